// File: rtl/descriptor_input_arbiter.sv
// ---------------------------------------------------------------------------
// descriptor_input_arbiter
//
// Merges descriptor streams from PORT_NUM ingress ports into one descriptor
// stream for the classification stage. Each port has a 2-entry FIFO to absorb
// simultaneous arrivals. A round-robin arbiter issues at most one descriptor
// per cycle. Drops caused by FIFO overflow are flagged per port and counted.
//
// Handshake: the ports have no backpressure. iv_descriptor_wr[p] is a one-cycle
// write strobe for the data in slice p. o_descriptor_wr is a one-cycle valid
// strobe for ov_descriptor. The downstream stage must accept every strobe.
//
// Ports:
//   i_clk            clock
//   i_rst            asynchronous, active-high reset
//   iv_descriptor    per-port descriptors; port p at [p*DESC_W +: DESC_W]
//   iv_descriptor_wr per-port write strobes
//   i_arb_en         1 = grants allowed; 0 = hold all FIFOs
//   i_drop_cnt_clr   synchronous clear of ov_drop_cnt (wins over new drops)
//   ov_descriptor    granted descriptor, registered (0 when none issued)
//   o_descriptor_wr  ov_descriptor valid strobe
//   ov_overflow      per-port one-cycle drop pulse
//   ov_drop_cnt      saturating total of dropped descriptors
// ---------------------------------------------------------------------------
module descriptor_input_arbiter #(
    parameter int PORT_NUM = 8,
    parameter int DESC_W   = 72
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [PORT_NUM*DESC_W-1:0]   iv_descriptor,
    input  logic [PORT_NUM-1:0]          iv_descriptor_wr,
    input  logic                         i_arb_en,
    input  logic                         i_drop_cnt_clr,
    output logic [DESC_W-1:0]            ov_descriptor,
    output logic                         o_descriptor_wr,
    output logic [PORT_NUM-1:0]          ov_overflow,
    output logic [15:0]                  ov_drop_cnt
);

    localparam int PTR_W     = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int CNT_SUM_W = $clog2(PORT_NUM + 1);

    // Per-port FIFO state. Depth 2, so the read and write pointers are 1 bit.
    logic [DESC_W-1:0]   fifo_mem [PORT_NUM][2];
    logic [PORT_NUM-1:0] fifo_wp;
    logic [PORT_NUM-1:0] fifo_rp;
    logic [1:0]          fifo_cnt [PORT_NUM];

    logic [PTR_W-1:0]    rr_ptr;

    logic [PORT_NUM-1:0] req;
    logic [PORT_NUM-1:0] pop;
    logic [PORT_NUM-1:0] drop;
    logic [PORT_NUM-1:0] accept;

    logic                grant_valid;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W:0]      idx_wide;
    logic [PTR_W-1:0]    idx_sel;
    logic [DESC_W-1:0]   head;

    logic [CNT_SUM_W-1:0] drop_sum;
    logic [16:0]          cnt_next;

    // Requests use the counts registered at the start of the cycle, so a
    // descriptor written this cycle can only be granted in the next cycle.
    always_comb begin
        req = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            req[p] = (fifo_cnt[p] != 2'd0);
        end
    end

    // Circular search for the first request, starting at rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx_wide    = '0;
        idx_sel     = '0;
        if (i_arb_en) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                idx_wide = {1'b0, rr_ptr} + (PTR_W+1)'(i);
                if (idx_wide >= (PTR_W+1)'(PORT_NUM)) begin
                    idx_wide = idx_wide - (PTR_W+1)'(PORT_NUM);
                end
                idx_sel = idx_wide[PTR_W-1:0];
                if (!grant_valid && req[idx_sel]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx_sel;
                end
            end
        end
    end

    assign head = fifo_mem[grant_idx][fifo_rp[grant_idx]];

    // A write to a full FIFO is accepted only if the same port is popped in
    // this cycle. That pop frees the slot the write needs.
    always_comb begin
        pop    = '0;
        drop   = '0;
        accept = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            pop[p]    = grant_valid && (grant_idx == PTR_W'(p));
            drop[p]   = iv_descriptor_wr[p] && (fifo_cnt[p] == 2'd2) && !pop[p];
            accept[p] = iv_descriptor_wr[p] && !drop[p];
        end
    end

    // FIFO storage does not need reset. Validity is tracked by fifo_cnt.
    always_ff @(posedge i_clk) begin
        for (int p = 0; p < PORT_NUM; p++) begin
            if (accept[p]) begin
                fifo_mem[p][fifo_wp[p]] <= iv_descriptor[p*DESC_W +: DESC_W];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fifo_wp <= '0;
            fifo_rp <= '0;
            for (int p = 0; p < PORT_NUM; p++) begin
                fifo_cnt[p] <= 2'd0;
            end
        end else begin
            for (int p = 0; p < PORT_NUM; p++) begin
                if (accept[p]) begin
                    fifo_wp[p] <= ~fifo_wp[p];
                end
                if (pop[p]) begin
                    fifo_rp[p] <= ~fifo_rp[p];
                end
                case ({accept[p], pop[p]})
                    2'b10:   fifo_cnt[p] <= fifo_cnt[p] + 2'd1;
                    2'b01:   fifo_cnt[p] <= fifo_cnt[p] - 2'd1;
                    default: fifo_cnt[p] <= fifo_cnt[p];
                endcase
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ov_descriptor   <= '0;
            o_descriptor_wr <= 1'b0;
            rr_ptr          <= '0;
        end else begin
            o_descriptor_wr <= grant_valid;
            ov_descriptor   <= grant_valid ? head : '0;
            if (grant_valid) begin
                if (grant_idx == PTR_W'(PORT_NUM - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + PTR_W'(1);
                end
            end
        end
    end

    // Count of ports that drop in this cycle.
    always_comb begin
        drop_sum = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            drop_sum = drop_sum + CNT_SUM_W'(drop[p]);
        end
    end

    assign cnt_next = {1'b0, ov_drop_cnt} + 17'(drop_sum);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ov_overflow <= '0;
            ov_drop_cnt <= '0;
        end else begin
            ov_overflow <= drop;
            if (i_drop_cnt_clr) begin
                ov_drop_cnt <= '0;
            end else if (cnt_next[16]) begin
                ov_drop_cnt <= 16'hFFFF;
            end else begin
                ov_drop_cnt <= cnt_next[15:0];
            end
        end
    end

endmodule
